// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and sizing helpers for the trace capture unit
//
// Contents:
//   tr_state_e : capture state encoding (TR_IDLE=0, TR_ARMED=1, TR_POST=2, TR_DONE=3)
//   entry_w()  : width of one stored {pc, instr} entry
//   ptr_w()    : buffer pointer width for a given depth
package trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE  = 2'd0,
    TR_ARMED = 2'd1,
    TR_POST  = 2'd2,
    TR_DONE  = 2'd3
  } tr_state_e;

  // Each entry holds one PC and one instruction word.
  localparam int unsigned ENTRY_FIELDS = 2;

  function automatic int unsigned entry_w(input int unsigned xlen);
    return ENTRY_FIELDS * xlen;
  endfunction

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// rtl/trace_buffer_if.sv - readout handshake bundle of the trace buffer
//
// Signals:
//   rd_valid : entry available (driven by the buffer)
//   rd_ready : consumer accepts the entry (driven by the consumer)
//   rd_pc    : PC of the presented entry
//   rd_instr : instruction of the presented entry
interface trace_buffer_if #(
  parameter int unsigned XLEN = 32
);
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_instr;

  modport master (output rd_valid, output rd_pc, output rd_instr, input rd_ready);
  modport slave  (input rd_valid, input rd_pc, input rd_instr, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read
//
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module trace_ram
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ptr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  // Contents are deliberately not reset; count decides which entries are live.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - PC/instruction trace capture with PC-match trigger and oldest-first readout
//
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   arm       : pulse; clears the buffer and starts capture
//   en        : sample qualifier
//   pc_in     : core debug PC
//   instr_in  : core debug instruction
//   trig_en   : enables the PC-match trigger
//   trig_pc   : trigger PC value
//   rd        : readout handshake (rd_valid/rd_ready/rd_pc/rd_instr)
//   triggered : trigger has fired in the current capture
//   state     : IDLE=0, ARMED=1, POST=2, DONE=3
//   count     : number of valid entries
module trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic                   en,
  input  logic [XLEN-1:0]        pc_in,
  input  logic [XLEN-1:0]        instr_in,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  trace_buffer_if.master         rd,
  output logic                   triggered,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = entry_w(XLEN);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  tr_state_e       state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   post_cnt_q, post_cnt_d;
  logic            triggered_q, triggered_d;

  logic            capturing;
  logic            sample;
  logic            hit;
  logic            rd_valid_w;
  logic            rd_fire;
  logic [EW-1:0]   rdata;

  assign capturing  = (state_q == TR_ARMED) || (state_q == TR_POST);
  // arm pre-empts any write in the same cycle.
  assign sample     = capturing && en && !arm;
  assign hit        = (state_q == TR_ARMED) && en && trig_en && (pc_in == trig_pc);
  assign rd_valid_w = (state_q == TR_DONE) && (count_q != '0);
  assign rd_fire    = rd_valid_w && rd.rd_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= TR_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      post_cnt_q  <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_cnt_q  <= post_cnt_d;
      triggered_q <= triggered_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    post_cnt_d  = post_cnt_q;
    triggered_d = triggered_q;

    if (arm) begin
      state_d     = TR_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      post_cnt_d  = CW'(POST_TRIG);
    end else begin
      // Circular write; once full the oldest entry is overwritten.
      if (sample) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        if (count_q != FULL) begin
          count_d = count_q + CW'(1);
        end
      end

      unique case (state_q)
        TR_ARMED: begin
          if (hit) begin
            triggered_d = 1'b1;
            state_d     = (POST_TRIG == 0) ? TR_DONE : TR_POST;
          end
        end
        TR_POST: begin
          if (sample) begin
            post_cnt_d = post_cnt_q - CW'(1);
            if (post_cnt_q == CW'(1)) begin
              state_d = TR_DONE;
            end
          end
        end
        TR_DONE: begin
          if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_d     = TR_IDLE;
              triggered_d = 1'b0;
            end
          end
        end
        default: begin
        end
      endcase

      // Point at the oldest entry on entry to DONE. When full, count's low
      // bits are zero, so this lands on wr_ptr, which is the oldest slot.
      if ((state_d == TR_DONE) && (state_q != TR_DONE)) begin
        rd_ptr_d = wr_ptr_d - count_d[PW-1:0];
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (sample),
    .waddr (wr_ptr_q),
    .wdata ({pc_in, instr_in}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign rd.rd_valid = rd_valid_w;
  assign rd.rd_pc    = rdata[EW-1:XLEN];
  assign rd.rd_instr = rdata[XLEN-1:0];
  assign triggered   = triggered_q;
  assign state       = state_q;
  assign count       = count_q;

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - scoreboard bench for trace_buffer
module tb_trace_buffer;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned POST_TRIG = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, arm, en, trig_en;
  logic [XLEN-1:0] pc_in, instr_in, trig_pc;
  logic            triggered, triggered0;
  logic [1:0]      state, state0;
  logic [4:0]      count;
  logic [2:0]      count0;

  trace_buffer_if #(.XLEN(XLEN)) rdi ();
  trace_buffer_if #(.XLEN(XLEN)) rdi0 ();

  trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) u_dut (
    .clk(clk), .reset(reset), .arm(arm), .en(en), .pc_in(pc_in), .instr_in(instr_in),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd(rdi), .triggered(triggered),
    .state(state), .count(count)
  );

  // Second instance: small buffer, no post-trigger window.
  trace_buffer #(.XLEN(XLEN), .DEPTH(4), .POST_TRIG(0)) u_dut0 (
    .clk(clk), .reset(reset), .arm(arm), .en(en), .pc_in(pc_in), .instr_in(instr_in),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd(rdi0), .triggered(triggered0),
    .state(state0), .count(count0)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: history of samples since arm, trimmed to DEPTH.
  logic [63:0] hist[$];
  logic [63:0] exp_q[$];
  bit          m_active = 0;
  bit          m_trig   = 0;
  int          post_left = 0;

  task automatic model_finish();
    m_active = 0;
    foreach (hist[k]) exp_q.push_back(hist[k]);
    hist.delete();
  endtask

  task automatic model_reset();
    m_active = 0;
    m_trig   = 0;
    hist.delete();
    exp_q.delete();
  endtask

  task automatic model_edge();
    if (arm) begin
      m_active  = 1;
      m_trig    = 0;
      post_left = POST_TRIG;
      hist.delete();
      exp_q.delete();
      return;
    end
    if (!m_active || !en) return;
    hist.push_back({pc_in, instr_in});
    if (hist.size() > DEPTH) void'(hist.pop_front());
    if (!m_trig) begin
      if (trig_en && pc_in == trig_pc) begin
        m_trig = 1;
        if (POST_TRIG == 0) model_finish();
      end
    end else begin
      post_left--;
      if (post_left == 0) model_finish();
    end
  endtask

  // Monitor runs at negedge; model updates after it for the coming edge.
  task automatic tick();
    @(negedge clk);
    #1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && rdi.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_valid: got 1 expected 0 (no entry pending)");
      end else begin
        check("rd_entry", {rdi.rd_pc, rdi.rd_instr}, exp_q[0]);
        check("rd_count", 64'(count), 64'(exp_q.size()));
        if (rdi.rd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drain(input bit rnd_ready);
    int n = 0;
    while ((exp_q.size() != 0 || m_active) && n < 200) begin
      if (rnd_ready) rdi.rd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    check("idle_state", 64'(state), 64'd0);
    check("idle_triggered", 64'(triggered), 64'd0);
    check("idle_rd_valid", 64'(rdi.rd_valid), 64'd0);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic run_early();
    rdi.rd_ready = 1'b1;
    do_arm();
    en = 1'b1;
    trig_en = 1'b1;
    trig_pc = 32'h08;
    for (int i = 0; i < 11; i++) begin
      pc_in = 32'(4 * i);
      instr_in = pc_in ^ 32'hFFFF;
      tick();
    end
    check("early_state", 64'(state), 64'd3);
    check("early_count", 64'(count), 64'd11);
    en = 1'b0;
    drain(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; arm = 1'b0; en = 1'b0; trig_en = 1'b0;
    pc_in = '0; instr_in = '0; trig_pc = '0;
    rdi.rd_ready = 1'b0;
    rdi0.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_rd_valid", 64'(rdi.rd_valid), 64'd0);
    check("rst_triggered", 64'(triggered), 64'd0);
    reset = 1'b1;

    // Wrap trigger with backpressure on the first entry.
    do_arm();
    check("arm_state", 64'(state), 64'd1);
    en = 1'b1;
    trig_en = 1'b1;
    trig_pc = 32'h40;
    for (int i = 0; i < 25; i++) begin
      pc_in = 32'(4 * i);
      instr_in = pc_in ^ 32'hFFFF;
      tick();
    end
    check("wrap_state", 64'(state), 64'd3);
    check("wrap_count", 64'(count), 64'd16);
    check("wrap_triggered", 64'(triggered), 64'd1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(rdi.rd_valid), 64'd1);
      check("bp_pc", 64'(rdi.rd_pc), 64'h24);
      check("bp_instr", 64'(rdi.rd_instr), 64'h24 ^ 64'hFFFF);
      check("bp_count", 64'(count), 64'd16);
      tick();
    end
    rdi.rd_ready = 1'b1;
    drain(1'b0);

    run_early();

    // en gaps during POST freeze the post-trigger countdown.
    do_arm();
    trig_pc = 32'h10;
    for (int i = 0; i <= 20; i++) begin
      en = (i <= 4) || (i % 2 == 0);
      pc_in = 32'(4 * i);
      instr_in = 32'(i * 7);
      tick();
      if (i == 19) check("gap_state_post", 64'(state), 64'd2);
      if (i == 20) begin
        check("gap_state_done", 64'(state), 64'd3);
        check("gap_count", 64'(count), 64'd13);
      end
    end
    en = 1'b0;
    drain(1'b0);

    // Reset pulse between edges while in POST.
    do_arm();
    en = 1'b1;
    trig_pc = 32'h08;
    for (int i = 0; i < 5; i++) begin
      pc_in = 32'(4 * i);
      instr_in = 32'(i);
      tick();
    end
    check("pre_rst_state", 64'(state), 64'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state", 64'(state), 64'd0);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_valid", 64'(rdi.rd_valid), 64'd0);
    check("mid_rst_triggered", 64'(triggered), 64'd0);
    model_reset();
    #2 reset = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    run_early();

    // arm and a trigger match in the same ARMED cycle.
    do_arm();
    en = 1'b1;
    trig_pc = 32'h40;
    pc_in = 32'h0; tick();
    pc_in = 32'h4; tick();
    arm = 1'b1;
    pc_in = 32'h40;
    tick();
    arm = 1'b0;
    check("armhit_state", 64'(state), 64'd1);
    check("armhit_count", 64'(count), 64'd0);
    check("armhit_triggered", 64'(triggered), 64'd0);
    en = 1'b0;

    // POST_TRIG=0 instance: trigger goes straight to DONE.
    rdi0.rd_ready = 1'b0;
    do_arm();
    en = 1'b1;
    trig_pc = 32'h18;
    for (int i = 0; i < 7; i++) begin
      pc_in = 32'(4 * i);
      instr_in = 32'(i);
      tick();
    end
    en = 1'b0;
    check("pt0_state", 64'(state0), 64'd3);
    check("pt0_triggered", 64'(triggered0), 64'd1);
    check("pt0_count", 64'(count0), 64'd4);
    rdi0.rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("pt0_valid", 64'(rdi0.rd_valid), 64'd1);
      check("pt0_pc", 64'(rdi0.rd_pc), 64'(4 * (3 + k)));
      tick();
    end
    check("pt0_idle", 64'(state0), 64'd0);
    check("pt0_trig_clr", 64'(triggered0), 64'd0);

    // Randomized captures checked by the scoreboard.
    for (int r = 0; r < 30; r++) begin
      int n;
      do_arm();
      trig_pc = 32'(4 * $urandom_range(0, 40));
      n = 0;
      while (m_active && n < 1000) begin
        en = ($urandom_range(0, 3) != 0);
        trig_en = ($urandom_range(0, 9) != 0);
        pc_in = 32'(4 * $urandom_range(0, 40));
        instr_in = $urandom;
        rdi.rd_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
        if (m_active) begin
          check("rnd_triggered", 64'(triggered), 64'(m_trig));
          check("rnd_state", 64'(state), m_trig ? 64'd2 : 64'd1);
        end
      end
      if (m_active) begin
        n_vec++;
        n_err++;
        $display("FAIL capture_timeout: got active expected done (round %0d)", r);
        model_reset();
      end
      drain(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
